// File: rtl/rst_seq_pkg.sv
// Shared state encoding and widths for the staged reset sequencer.
// Pure types and helpers; no latency, no flow control.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    PLL_WAIT = 3'd1,
    DAC      = 3'd2,
    RUN      = 3'd3,
    FAIL     = 3'd4
  } state_t;

  localparam int RETRY_W = 2;

  // {pll_rst, dac_rst, dsp_rst} for a given state; release is strictly ordered
  function automatic logic [2:0] rst_decode(state_t s);
    logic [2:0] r;
    case (s)
      PLL_WAIT: r = 3'b011;
      DAC:      r = 3'b001;
      RUN:      r = 3'b000;
      default:  r = 3'b111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle between the reset sequencer and the TX chain.
// Level signals only; no latency of its own, no backpressure.
interface rst_seq_if;
  import rst_seq_pkg::*;

  logic               soft_rst;
  logic               pll_locked;
  logic               pll_rst;
  logic               dac_rst;
  logic               dsp_rst;
  logic               ready;
  logic               fail;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  soft_rst, pll_locked,
    output pll_rst, dac_rst, dsp_rst, ready, fail, lock_lost, retry_cnt
  );

  modport slave (
    output soft_rst, pll_locked,
    input  pll_rst, dac_rst, dsp_rst, ready, fail, lock_lost, retry_cnt
  );

endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
// Latency 2 cycles; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged PLL -> DAC -> DSP reset release with lock qualification, timeout retry and sticky fail.
// Outputs registered from next state (1 cycle); no backpressure, status-only outputs.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DAC_DLY      = 32,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  rst_seq_if.master bus
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;
  localparam bit CFG_OK = (CNT_W >= 1) && (CNT_W <= 31) &&
                          (HOLD_CYCLES  >= 1) && (HOLD_CYCLES  < CNT_LIM) &&
                          (LOCK_STABLE  >= 1) && (LOCK_STABLE  < CNT_LIM) &&
                          (LOCK_TIMEOUT >= 1) && (LOCK_TIMEOUT < CNT_LIM) &&
                          (DAC_DLY      >= 1) && (DAC_DLY      < CNT_LIM) &&
                          (MAX_RETRY    >= 0) && (MAX_RETRY    < (1 << RETRY_W));

  if (!CFG_OK) begin : g_cfg_err
    $error("rst_sequencer: a count parameter does not fit CNT_W or MAX_RETRY exceeds retry_cnt");
  end

  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DAC_LAST     = CNT_W'(DAC_DLY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   stable, stable_nxt;
  logic [CNT_W-1:0]   tcnt, tcnt_nxt;
  logic [RETRY_W-1:0] retry_q, retry_nxt;
  logic               pll_lk_s;
  logic               enter_hold;

  logic pll_rst_d, dac_rst_d, dsp_rst_d, ready_d, fail_d, lock_lost_d;
  logic pll_rst_q, dac_rst_q, dsp_rst_q, ready_q, fail_q, lock_lost_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.pll_locked),
    .q     (pll_lk_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= HOLD;
      cnt     <= '0;
      stable  <= '0;
      tcnt    <= '0;
      retry_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      stable  <= stable_nxt;
      tcnt    <= tcnt_nxt;
      retry_q <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    tcnt_nxt   = tcnt;
    retry_nxt  = retry_q;
    if (bus.soft_rst) begin
      state_nxt = HOLD;
      retry_nxt = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = PLL_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PLL_WAIT: begin
          tcnt_nxt   = tcnt + CNT_ONE;
          stable_nxt = pll_lk_s ? stable + CNT_ONE : '0;
          // qualification wins over a timeout landing on the same cycle
          if (pll_lk_s && stable == STABLE_LAST) begin
            state_nxt  = DAC;
            stable_nxt = '0;
            tcnt_nxt   = '0;
          end else if (tcnt == TIMEOUT_LAST) begin
            stable_nxt = '0;
            tcnt_nxt   = '0;
            if (retry_q < RETRY_MAX) begin
              state_nxt = HOLD;
              retry_nxt = retry_q + RETRY_ONE;
            end else begin
              state_nxt = FAIL;
            end
          end
        end
        DAC: begin
          if (!pll_lk_s) begin
            state_nxt = HOLD;
          end else if (cnt == DAC_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!pll_lk_s) begin
            state_nxt = HOLD;
            retry_nxt = '0;
          end
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = HOLD;
      endcase
    end
    // a fresh HOLD always starts its counters from zero
    enter_hold = bus.soft_rst || (state != HOLD && state_nxt == HOLD);
    if (enter_hold) begin
      cnt_nxt    = '0;
      stable_nxt = '0;
      tcnt_nxt   = '0;
    end
  end

  always_comb begin
    {pll_rst_d, dac_rst_d, dsp_rst_d} = rst_decode(state_nxt);
    ready_d     = (state_nxt == RUN);
    fail_d      = (state_nxt == FAIL);
    lock_lost_d = (state == RUN) && (state_nxt == HOLD) && !bus.soft_rst;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q   <= 1'b1;
      dac_rst_q   <= 1'b1;
      dsp_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      dac_rst_q   <= dac_rst_d;
      dsp_rst_q   <= dsp_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dac_rst   = dac_rst_q;
  assign bus.dsp_rst   = dsp_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;

  a_release_order: assert property (@(posedge clk) disable iff (!reset_n)
    (dac_rst_q || !pll_rst_q) && (dsp_rst_q || !dac_rst_q));

  a_ready_run: assert property (@(posedge clk) disable iff (!reset_n)
    (ready_q == !dsp_rst_q) && !(ready_q && fail_q));

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed scoreboard bench for rst_sequencer with shortened timing parameters.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rst_seq_if bus();

  rst_sequencer #(
    .HOLD_CYCLES  (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .DAC_DLY      (4),
    .MAX_RETRY    (2),
    .CNT_W        (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         at;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tot    = 0;
  int   base   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) tot <= tot + 1;

  localparam int S_HOLD = 0, S_PLLW = 1, S_DAC = 2, S_RUN = 3, S_FAIL = 4;

  // {pll_rst, dac_rst, dsp_rst, ready, fail, lock_lost, retry_cnt[1:0]}
  function automatic logic [7:0] vec(int st, int rc, bit ll);
    logic [2:0] r;
    logic       rdy;
    logic       fl;
    logic [1:0] rcv;
    r   = 3'b111;
    rdy = 1'b0;
    fl  = 1'b0;
    rcv = 2'(rc);
    case (st)
      S_PLLW: r = 3'b011;
      S_DAC:  r = 3'b001;
      S_RUN:  begin r = 3'b000; rdy = 1'b1; end
      S_FAIL: fl = 1'b1;
      default: r = 3'b111;
    endcase
    return {r, rdy, fl, ll, rcv};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.pll_rst, bus.dac_rst, bus.dsp_rst, bus.ready, bus.fail,
            bus.lock_lost, bus.retry_cnt};
  endfunction

  task automatic expect_at(int k, string tag, logic [7:0] v);
    exp_t e;
    e.at  = base + k;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_now(string tag, logic [7:0] v);
    exp_t e;
    e.at  = tot;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0 && sb[0].at <= tot) begin
      e   = sb.pop_front();
      got = obs();
      n_chk++;
      assert (got === e.exp) else begin
        n_fail++;
        $error("FAIL %s @edge %0d: observed %b expected %b", e.tag, e.at - base, got, e.exp);
      end
    end
  endtask

  task automatic step_to(int k);
    int guard;
    guard = 0;
    while (tot < base + k) begin
      @(negedge clk);
      check_due();
      guard++;
      if (guard > 5000) begin
        n_fail++;
        $display("FAIL step_to: reached edge %0d, required %0d", tot - base, k);
        return;
      end
    end
  endtask

  task automatic do_reset(bit lock);
    @(negedge clk);
    reset_n        = 1'b0;
    bus.pll_locked = lock;
    bus.soft_rst   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base    = tot;
  endtask

  initial begin
    bus.soft_rst   = 1'b0;
    bus.pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    expect_now("reset_state", vec(S_HOLD, 0, 0));
    check_due();
    reset_n = 1'b1;
    base    = tot;

    // locked from the start, then lock drops in RUN and later returns
    expect_at(1,  "c1_hold_e1",  vec(S_HOLD, 0, 0));
    expect_at(3,  "c1_hold_e3",  vec(S_HOLD, 0, 0));
    expect_at(4,  "c1_pll_rel",  vec(S_PLLW, 0, 0));
    expect_at(11, "c1_pllw_e11", vec(S_PLLW, 0, 0));
    expect_at(12, "c1_dac_rel",  vec(S_DAC,  0, 0));
    expect_at(15, "c1_dac_e15",  vec(S_DAC,  0, 0));
    expect_at(16, "c1_run",      vec(S_RUN,  0, 0));
    expect_at(29, "c3_run_e29",  vec(S_RUN,  0, 0));
    expect_at(31, "c3_run_e31",  vec(S_RUN,  0, 0));
    expect_at(32, "c3_lost",     vec(S_HOLD, 0, 1));
    expect_at(33, "c3_pulse_end", vec(S_HOLD, 0, 0));
    expect_at(35, "c3_hold_e35", vec(S_HOLD, 0, 0));
    expect_at(36, "c3_pllw",     vec(S_PLLW, 0, 0));
    expect_at(48, "c3_pllw_e48", vec(S_PLLW, 0, 0));
    expect_at(49, "c3_dac",      vec(S_DAC,  0, 0));
    expect_at(52, "c3_dac_e52",  vec(S_DAC,  0, 0));
    expect_at(53, "c3_run",      vec(S_RUN,  0, 0));
    step_to(29);
    bus.pll_locked = 1'b0;
    step_to(39);
    bus.pll_locked = 1'b1;
    step_to(55);

    // no lock: two retries, then FAIL; then soft restart from FAIL and from RUN
    do_reset(1'b0);
    expect_at(4,   "c2_pllw0",   vec(S_PLLW, 0, 0));
    expect_at(35,  "c2_pllw0_e", vec(S_PLLW, 0, 0));
    expect_at(36,  "c2_retry1",  vec(S_HOLD, 1, 0));
    expect_at(39,  "c2_hold1_e", vec(S_HOLD, 1, 0));
    expect_at(40,  "c2_pllw1",   vec(S_PLLW, 1, 0));
    expect_at(71,  "c2_pllw1_e", vec(S_PLLW, 1, 0));
    expect_at(72,  "c2_retry2",  vec(S_HOLD, 2, 0));
    expect_at(76,  "c2_pllw2",   vec(S_PLLW, 2, 0));
    expect_at(107, "c2_pllw2_e", vec(S_PLLW, 2, 0));
    expect_at(108, "c2_fail",    vec(S_FAIL, 2, 0));
    expect_at(119, "c2_fail_sticky", vec(S_FAIL, 2, 0));
    expect_at(120, "c5_soft_fail",   vec(S_HOLD, 0, 0));
    expect_at(123, "c5_hold_e3",     vec(S_HOLD, 0, 0));
    expect_at(124, "c5_pll_rel",     vec(S_PLLW, 0, 0));
    expect_at(131, "c5_pllw_e11",    vec(S_PLLW, 0, 0));
    expect_at(132, "c5_dac_rel",     vec(S_DAC,  0, 0));
    expect_at(135, "c5_dac_e15",     vec(S_DAC,  0, 0));
    expect_at(136, "c5_run",         vec(S_RUN,  0, 0));
    expect_at(139, "c5_run_e",       vec(S_RUN,  0, 0));
    expect_at(140, "c5_soft_run",    vec(S_HOLD, 0, 0));
    expect_at(141, "c5_soft_level",  vec(S_HOLD, 0, 0));
    expect_at(144, "c5_hold_e3b",    vec(S_HOLD, 0, 0));
    expect_at(145, "c5_pll_rel_b",   vec(S_PLLW, 0, 0));
    expect_at(152, "c5_pllw_b",      vec(S_PLLW, 0, 0));
    expect_at(153, "c5_dac_rel_b",   vec(S_DAC,  0, 0));
    expect_at(156, "c5_dac_b",       vec(S_DAC,  0, 0));
    expect_at(157, "c5_run_b",       vec(S_RUN,  0, 0));
    step_to(110);
    bus.pll_locked = 1'b1;
    step_to(119);
    bus.soft_rst = 1'b1;
    step_to(120);
    bus.soft_rst = 1'b0;
    step_to(139);
    bus.soft_rst = 1'b1;
    step_to(141);
    bus.soft_rst = 1'b0;
    step_to(158);

    // one-cycle lock glitch while qualifying
    do_reset(1'b1);
    expect_at(4,  "c4_pll_rel",  vec(S_PLLW, 0, 0));
    expect_at(12, "c4_no_dac",   vec(S_PLLW, 0, 0));
    expect_at(16, "c4_pllw_e16", vec(S_PLLW, 0, 0));
    expect_at(17, "c4_dac_rel",  vec(S_DAC,  0, 0));
    expect_at(20, "c4_dac_e20",  vec(S_DAC,  0, 0));
    expect_at(21, "c4_run",      vec(S_RUN,  0, 0));
    step_to(6);
    bus.pll_locked = 1'b0;
    step_to(7);
    bus.pll_locked = 1'b1;
    step_to(22);

    // asynchronous reset in the middle of DAC, then clean restart
    do_reset(1'b1);
    expect_at(12, "c6_dac_rel", vec(S_DAC, 0, 0));
    expect_at(14, "c6_dac_mid", vec(S_DAC, 0, 0));
    step_to(14);
    reset_n = 1'b0;
    #1;
    expect_now("c6_async_rst", vec(S_HOLD, 0, 0));
    check_due();
    repeat (2) @(negedge clk);
    expect_now("c6_rst_held", vec(S_HOLD, 0, 0));
    check_due();
    reset_n = 1'b1;
    base    = tot;
    expect_at(3,  "c6_hold_e3",  vec(S_HOLD, 0, 0));
    expect_at(4,  "c6_pll_rel",  vec(S_PLLW, 0, 0));
    expect_at(11, "c6_pllw_e11", vec(S_PLLW, 0, 0));
    expect_at(12, "c6_dac_rel2", vec(S_DAC,  0, 0));
    expect_at(15, "c6_dac_e15",  vec(S_DAC,  0, 0));
    expect_at(16, "c6_run",      vec(S_RUN,  0, 0));
    step_to(18);

    while (sb.size() > 0) begin
      n_fail++;
      $display("FAIL %s: still pending at edge %0d, required by edge %0d",
               sb[0].tag, tot - base, sb[0].at - base);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
